// File: rtl/uart_tx.sv
// UART transmitter fed by a fifo_sync read port: start bit, DATA_WIDTH bits LSB first,
// optional even parity (define UART_TX_PARITY_EN), one stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_dout,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, START = 3'd3,
    DATA = 3'd4, PARITY = 3'd5, STOP = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, START = 3'd3,
    DATA = 3'd4, STOP = 3'd6
  } state_t;
`endif

  state_t                state_reg, state_next;
  logic [CW-1:0]         baud_reg, baud_next;
  logic [IW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif
  logic                  bit_end;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign bit_end = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_enable && !i_fifo_empty) state_next = FETCH;
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        // fifo data is valid here, one cycle after the read strobe
        shift_next = i_fifo_dout;
        baud_next  = '0;
        bit_next   = '0;
`ifdef UART_TX_PARITY_EN
        parity_next = ^i_fifo_dout;
`endif
        state_next = START;
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = (i_enable && !i_fifo_empty) ? FETCH : IDLE;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // line level is registered from the upcoming state so START appears right after LOAD
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign o_tx      = tx_reg;
  assign o_fifo_rd = (state_reg == FETCH);
  assign o_busy    = (state_reg != IDLE);
  assign o_done    = (state_reg == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a fifo_sync model and a frame scoreboard.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_dout = 8'h00;
  logic       tx, busy, done;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en), .i_fifo_empty(fifo_empty),
    .o_fifo_rd(fifo_rd), .i_fifo_dout(fifo_dout), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int rd_count = 0;
  int overrun = 0;
  int cyc = 0;
  int last_rd_cyc = -100;
  int done_total = 0;
  int frames_seen = 0;
  int aborted_frames = 0;
  int cur_k = -1;

  assign fifo_empty = (fifo_q.size() == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fifo_sync model: data appears on dout the cycle after the strobe
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd === 1'b1) begin
      rd_count++;
      if (fifo_q.size() == 0) overrun++;
      else fifo_dout <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (fifo_rd === 1'b1) last_rd_cyc = cyc;
    if (done === 1'b1) done_total++;
  end

  // frame monitor: scores every frame that starts on the line against the scoreboard
  initial begin
    logic [7:0]  b;
    logic [15:0] fbits;
    logic        ok, aborted;
    int          dcnt, dpos, lat;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        b = 8'hxx;
        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
        else b = exp_q.pop_front();
        fbits = '1;
        fbits[0] = 1'b0;
        for (int i = 0; i < 8; i++) fbits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        fbits[9] = ^b;
`endif
        lat = cyc - last_rd_cyc;
        ok = 1'b1; aborted = 1'b0; dcnt = 0; dpos = -1;
        for (int k = 0; k < NB*CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (rstn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          cur_k = k;
          if (tx !== fbits[k/CPB] || busy !== 1'b1) ok = 1'b0;
          if (done === 1'b1) begin
            dcnt++;
            dpos = k;
          end
        end
        cur_k = -1;
        if (aborted) begin
          aborted_frames++;
          check("abort_no_done", dcnt, 0);
        end else begin
          $display("frame byte=%02h ok=%0d done_count=%0d done_at=%0d latency=%0d", b, ok, dcnt, dpos, lat);
          check("frame_bits", ok, 1);
          check("done_once", dcnt, 1);
          check("done_pos", dpos, NB*CPB-1);
          check("rd_to_start", lat, 2);
          frames_seen++;
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target);
    int budget = 1000;
    while (frames_seen < target && budget > 0) begin
      tick(1);
      budget--;
    end
    check("frame_timeout", frames_seen, target);
  endtask

  task automatic wait_k(input int target);
    int budget = 300;
    while (cur_k != target && budget > 0) begin
      tick(1);
      budget--;
    end
    check("bit_wait_timeout", cur_k, target);
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  initial begin
    int rd0, dn0, drops, ok_flag;

    // reset held with data available and enable high
    fifo_q.push_back(8'h11);
    @(posedge clk);
    ok_flag = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) ok_flag = 0;
    end
    $display("reset hold: outputs idle=%0d", ok_flag);
    check("reset_hold_idle", ok_flag, 1);
    check("reset_no_rd", rd_count, 0);
    #1;
    fifo_q.delete();
    rstn = 1'b1;
    tick(5);
    check("post_reset_tx", tx, 1);
    check("post_reset_busy", busy, 0);

    // single byte
    rd0 = rd_count;
    send(8'hA5);
    wait_frames(1);
    tick(10);
    $display("0xA5: reads=%0d busy=%0d", rd_count - rd0, busy);
    check("a5_reads", rd_count - rd0, 1);
    check("a5_idle", busy, 0);

    // three queued bytes back to back
    rd0 = rd_count;
    send(8'h00); send(8'hFF); send(8'h3C);
    tick(2);
    drops = 0;
    for (int budget = 0; frames_seen < 4 && budget < 1000; budget++) begin
      tick(1);
      if (busy !== 1'b1) drops++;
    end
    check("b2b_frames", frames_seen, 4);
    tick(10);
    $display("b2b: reads=%0d busy_drops=%0d fifo_left=%0d", rd_count - rd0, drops, fifo_q.size());
    check("b2b_busy_high", drops, 0);
    check("b2b_reads", rd_count - rd0, 3);
    check("b2b_fifo_empty", fifo_q.size(), 0);
    check("overrun", overrun, 0);

    // enable dropped during data bit 2
    rd0 = rd_count;
    send(8'h5A);
    fifo_q.push_back(8'hC3);
    wait_k(3*CPB);
    en = 1'b0;
    wait_frames(5);
    tick(20);
    $display("enable drop: reads=%0d busy=%0d fifo_left=%0d", rd_count - rd0, busy, fifo_q.size());
    check("en_reads", rd_count - rd0, 1);
    check("en_idle", busy, 0);
    check("en_fifo_left", fifo_q.size(), 1);
    fifo_q.delete();
    en = 1'b1;

    // reset during data bit 3
    rd0 = rd_count;
    dn0 = done_total;
    send(8'h96);
    wait_k(4*CPB + 1);
    rstn = 1'b0;
    tick(1);
    $display("mid-frame reset: tx=%0d busy=%0d", tx, busy);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    tick(2);
    rstn = 1'b1;
    tick(20);
    check("rst_aborted", aborted_frames, 1);
    check("rst_no_done", done_total - dn0, 0);
    check("rst_reads", rd_count - rd0, 1);
    check("rst_frames", frames_seen, 5);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    send(8'h03);
    wait_frames(7);
    tick(10);
    check("par_idle", busy, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 CLKS_PER_BIT, 868, i_clk cycles per serial bit (legal >= 2).
REQ-002 DATA_WIDTH, 8, bits per character.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  reset, synchronous, active-low.
REQ-005 i_enable  input  1  transmit enable; low blocks new fetches.
REQ-006 i_fifo_empty  input  1  empty flag from upstream fifo_sync.
REQ-007 o_fifo_rd  output  1  one-cycle read strobe to fifo_sync.
REQ-008 i_fifo_dout  input  DATA_WIDTH  fifo_sync read data; valid the cycle after o_fifo_rd.
REQ-009 o_tx  output  1  registered serial line; idle high.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY (macro builds only), and STOP.
REQ-013 IDLE -> FETCH when i_enable=1 and i_fifo_empty=0; o_fifo_rd=1 for exactly the single FETCH cycle.
REQ-014 FETCH -> LOAD unconditionally; LOAD captures i_fifo_dout into the shift register; LOAD -> START.
REQ-015 Latency: o_tx goes low two cycles after the o_fifo_rd cycle.
REQ-016 START, each DATA bit, PARITY and STOP are held on o_tx for exactly CLKS_PER_BIT cycles.
REQ-017 Bit timing uses a baud counter of width $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and clears on every bit boundary.
REQ-018 DATA sends DATA_WIDTH bits LSB first; the bit index wraps to 0 after DATA_WIDTH-1 and exits to PARITY or STOP.
REQ-019 STOP drives o_tx=1 and asserts o_done on its last cycle.
REQ-020 STOP exit: -> FETCH if i_enable=1 and i_fifo_empty=0 (back-to-back frames, no idle gap); otherwise -> IDLE.
REQ-021 o_fifo_rd SHALL never assert while i_fifo_empty=1 is sampled.
REQ-022 o_fifo_rd asserts at most once per frame.
REQ-023 Deasserting i_enable mid-frame does not abort the frame; the frame completes and no further fetch occurs.
REQ-024 Changes on i_fifo_empty and i_fifo_dout outside FETCH/LOAD SHALL NOT affect the frame in flight.

Reset
REQ-025 When i_rstn=0 is sampled: state=IDLE, o_tx=1, o_busy=0, o_fifo_rd=0, o_done=0, and all counters and the shift register are cleared.
REQ-026 Reset mid-frame aborts the frame: o_tx=1 from the next cycle, o_done is not asserted, and the byte is lost (not re-read).
REQ-027 Reset during FETCH or LOAD drops the already-popped byte; no second read occurs for it.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, the PARITY state follows DATA and drives even parity (XOR of the data bits) for CLKS_PER_BIT cycles; the default frame is 11 bits.
REQ-029 With UART_TX_PARITY_EN undefined, the PARITY state does not exist, DATA -> STOP, and the default frame is 10 bits.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-030 Hold i_rstn=0 with i_fifo_empty=0 and i_enable=1 for 20 cycles -> o_tx=1, o_fifo_rd=0, o_busy=0 throughout.
REQ-031 Send one byte 0xA5, with empty rising after the read -> exactly one o_fifo_rd pulse.
REQ-032 For the 0xA5 frame, o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_done pulses once, 40 cycles after START begins; the block then returns to IDLE.
REQ-033 Queue 0x00, 0xFF, 0x3C in fifo_sync -> three contiguous 40-cycle frames; o_busy stays high throughout; exactly 3 o_fifo_rd pulses; fifo_sync empty with no overrun.
REQ-034 Drop i_enable during data bit 2 with the fifo non-empty -> the frame completes, then the block goes to IDLE with no further o_fifo_rd.
REQ-035 Assert reset during data bit 3 -> o_tx=1 and o_busy=0 next cycle, and no o_done.
REQ-036 With UART_TX_PARITY_EN: 0x07 -> parity bit 1; 0x03 -> parity bit 0; each frame is 44 cycles.
